spmv_mac_backend: RTL and testbench

Row-accumulating multiply-accumulate back end for the HHT sparse matrix–vector engine. Consumes the stream of (matrix value, vector value) pairs fetched by the HHT `control` front end from the CSR arrays, with one row-end marker per row. Produces one dot-product result per matrix row, in row order, through a small output FIFO with valid/ready flow control. Sits directly downstream of `control` and upstream of the result write-back.

---
 rtl/spmv_mac_backend.sv | 183 ++++++++++++++++++
 tb/tb_spmv_mac_backend.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_mac_backend.sv
`default_nettype none
// ============================================================================
// Module   : spmv_mac_backend
// Purpose  : Row-accumulating multiply-accumulate back end for the sparse
//            matrix-vector engine. Takes (matrix value, vector value) beats
//            with a row-end marker. Emits one dot product per row, in row
//            order, through a show-ahead output FIFO.
// Ports    : Clk, Rst (sync, active-low)
//            start / num_rows      - job launch, row count sampled on start
//            in_*                  - beat stream (valid/ready, last, empty)
//            out_*                 - result stream (valid/ready, row, sum)
//            busy / done / ovf     - job status, done is a 1-cycle pulse,
//                                    ovf is sticky until the next start
// Revision : 1.0 - initial release
// ============================================================================
module spmv_mac_backend #(
    parameter int ACC_W      = 48,
    parameter int ROW_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_mval,
    input  logic [31:0]      in_vval,
    input  logic             in_last,
    input  logic             in_empty,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_row,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_CMP_W = ROW_W + c_CNT_W;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [ROW_W-1:0]   r_num_rows;
    logic [ROW_W-1:0]   r_rows_acc;   // row-end beats accepted
    logic [ROW_W-1:0]   r_row_idx;    // rows written to the FIFO
    logic               r_s1_valid;
    logic               r_s1_last;
    logic [ACC_W-1:0]   r_s1_prod;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;

    logic [ROW_W-1:0]   r_mem_row [FIFO_DEPTH];
    logic [ACC_W-1:0]   r_mem_sum [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_room;
    logic [c_CNT_W-1:0] w_free;
    logic [ROW_W-1:0]   w_inflight;
    logic [ACC_W:0]     w_sum;

    // Row ends accepted but not yet written hold a reserved FIFO slot each,
    // so a write from stage 2 can never find the FIFO full.
    assign w_inflight = r_rows_acc - r_row_idx;
    assign w_free     = c_CNT_W'(FIFO_DEPTH) - r_count;
    assign w_room     = c_CMP_W'(w_free) > c_CMP_W'(w_inflight);

    assign in_ready   = (r_state == c_RUN) && (r_rows_acc < r_num_rows) && w_room;
    assign w_accept   = in_valid && in_ready;

    // Extra bit catches the carry-out that sets the sticky overflow flag.
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_s1_prod};
    assign w_push     = r_s1_valid && r_s1_last;
    assign w_pop      = (r_count != '0) && out_ready;

    assign out_valid  = (r_count != '0);
    assign out_row    = out_valid ? r_mem_row[r_rd_ptr] : '0;
    assign out_sum    = out_valid ? r_mem_sum[r_rd_ptr] : '0;
    assign busy       = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign done       = (r_state == c_DONE);
    assign ovf        = r_ovf;

    // FIFO storage carries no reset; the read side is masked by out_valid.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem_row[r_wr_ptr] <= r_row_idx;
            r_mem_sum[r_wr_ptr] <= w_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state    <= c_IDLE;
            r_num_rows <= '0;
            r_rows_acc <= '0;
            r_row_idx  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_prod  <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            // Stage 1: only the low ACC_W product bits reach the accumulator.
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last <= in_last;
                r_s1_prod <= in_empty ? '0
                           : ACC_W'({32'd0, in_mval} * {32'd0, in_vval});
            end
            if (w_accept && in_last) begin
                r_rows_acc <= r_rows_acc + 1'b1;
            end

            // Stage 2: accumulate, and close the row on a last beat.
            if (r_s1_valid) begin
                if (w_sum[ACC_W]) begin
                    r_ovf <= 1'b1;
                end
                if (r_s1_last) begin
                    r_acc     <= '0;
                    r_row_idx <= r_row_idx + 1'b1;
                end else begin
                    r_acc <= w_sum[ACC_W-1:0];
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            // Placed last so the job-start clears take priority.
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_num_rows <= num_rows;
                        r_rows_acc <= '0;
                        r_row_idx  <= '0;
                        r_acc      <= '0;
                        r_ovf      <= 1'b0;
                        r_state    <= (num_rows == '0) ? c_DONE : c_RUN;
                    end
                end
                c_RUN: begin
                    if (r_row_idx == r_num_rows) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (r_count == '0) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spmv_mac_backend.sv
`default_nettype none
// ============================================================================
// Module   : tb_spmv_mac_backend
// Purpose  : Self-checking bench for spmv_mac_backend. Table vectors,
//            hand-written corner sequences and randomized jobs checked
//            against a row-sum reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spmv_mac_backend;

    localparam int ACC_W      = 48;
    localparam int ROW_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int LIMIT      = 3000;
    localparam logic [63:0] c_MOD = 64'h0001_0000_0000_0000;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             start = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_mval = '0;
    logic [31:0]      in_vval = '0;
    logic             in_last = 1'b0;
    logic             in_empty = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ROW_W-1:0] out_row;
    logic [ACC_W-1:0] out_sum;
    logic             busy;
    logic             done;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    spmv_mac_backend #(
        .ACC_W      (ACC_W),
        .ROW_W      (ROW_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .num_rows  (num_rows),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mval   (in_mval),
        .in_vval   (in_vval),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_sum   (out_sum),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    typedef struct {
        logic [31:0] m;
        logic [31:0] v;
        bit          last;
        bit          empty;
    } beat_t;

    typedef struct {
        logic [31:0]      m;
        logic [31:0]      v;
        bit               empty;
        logic [ACC_W-1:0] exp;
    } vec_t;

    beat_t            beats[$];
    logic [ACC_W-1:0] exp_sum[$];
    bit               exp_ovf;
    int               held_accepts;
    vec_t             tbl[7];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Row sum = plain sum of the ACC_W-bit truncated products, reduced
    // modulo 2^ACC_W; overflow iff that plain sum reached 2^ACC_W.
    task automatic build_expected;
        logic [63:0] row_total;
        logic [63:0] p;
        exp_sum.delete();
        exp_ovf   = 1'b0;
        row_total = '0;
        foreach (beats[i]) begin
            p = beats[i].empty ? 64'd0 : {32'd0, beats[i].m} * {32'd0, beats[i].v};
            row_total = row_total + (p % c_MOD);
            if (beats[i].last) begin
                if (row_total >= c_MOD) exp_ovf = 1'b1;
                exp_sum.push_back(ACC_W'(row_total % c_MOD));
                row_total = '0;
            end
        end
    endtask

    task automatic add_row(input int nbeats, input bit empty, input bit big);
        logic [31:0] m;
        logic [31:0] v;
        if (empty) begin
            beats.push_back('{$urandom, $urandom, 1'b1, 1'b1});
        end else begin
            for (int k = 0; k < nbeats; k++) begin
                m = big ? ($urandom | 32'hF000_0000) : 32'($urandom_range(0, 1000));
                v = big ? ($urandom | 32'hF000_0000) : 32'($urandom_range(0, 1000));
                beats.push_back('{m, v, (k == nbeats - 1), 1'b0});
            end
        end
    endtask

    // Runs one job over the beats queue; results compared to exp_sum.
    task automatic run_job(input int pv, input int pr, input int hold, input int restart_at);
        int  nrows;
        int  bi;
        int  popped;
        int  dcyc;
        int  mcyc;
        bit  acc;
        bit  restarted;
        nrows     = exp_sum.size();
        bi        = 0;
        popped    = 0;
        dcyc      = 0;
        mcyc      = 0;
        restarted = 1'b0;
        held_accepts = 0;
        num_rows = ROW_W'(nrows);
        start    = 1'b1;
        tick;
        start    = 1'b0;
        num_rows = ROW_W'($urandom);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("ovf_cleared_on_start", {63'd0, ovf}, 64'd0);
        fork
            begin
                while (bi < beats.size() && dcyc < LIMIT) begin
                    in_valid = ($urandom_range(0, 99) < pv);
                    in_mval  = in_valid ? beats[bi].m : $urandom;
                    in_vval  = in_valid ? beats[bi].v : $urandom;
                    in_last  = in_valid ? beats[bi].last : 1'($urandom);
                    in_empty = in_valid ? beats[bi].empty : 1'($urandom);
                    if (bi == restart_at && !restarted) begin
                        start     = 1'b1;
                        num_rows  = ROW_W'(nrows + 3);
                        restarted = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                    if (hold > 0 && dcyc == hold - 1)
                        chk("in_ready_low_when_full", {63'd0, in_ready}, 64'd0);
                    acc = in_valid && in_ready;
                    tick;
                    if (acc) begin
                        if (dcyc < hold) held_accepts++;
                        bi++;
                    end
                    dcyc++;
                end
                in_valid = 1'b0;
                start    = 1'b0;
            end
            begin
                while (popped < nrows && mcyc < LIMIT) begin
                    out_ready = (mcyc < hold) ? 1'b0 : ($urandom_range(0, 99) < pr);
                    if (out_valid && out_ready) begin
                        chk("out_row", 64'(out_row), 64'(popped));
                        chk("out_sum", 64'(out_sum), 64'(exp_sum[popped]));
                        popped++;
                    end
                    tick;
                    mcyc++;
                end
                out_ready = 1'b0;
            end
        join
        chk("all_beats_accepted", 64'(bi), 64'(beats.size()));
        chk("all_rows_popped", 64'(popped), 64'(nrows));
        chk("out_valid_after_drain", {63'd0, out_valid}, 64'd0);
        tick;
        chk("done_after_last_pop", {63'd0, done}, 64'd1);
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);
        chk("ovf_at_done", {63'd0, ovf}, {63'd0, exp_ovf});
        tick;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out_row"}, 64'(out_row), 64'd0);
        chk({tag, "_out_sum"}, 64'(out_sum), 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
    endtask

    logic [31:0] seq_m[7];
    logic [31:0] seq_v[7];

    initial begin
        tbl[0] = '{32'd5,         32'd7,         1'b0, 48'd35};
        tbl[1] = '{32'd0,         32'd123,       1'b0, 48'd0};
        tbl[2] = '{32'd1000,      32'd1000,      1'b0, 48'd1000000};
        tbl[3] = '{32'd9,         32'd9,         1'b1, 48'd0};
        tbl[4] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 48'h0000_FFFF_FFFF};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 48'hFFFE_0000_0001};
        tbl[6] = '{32'd65536,     32'd65536,     1'b0, 48'h0001_0000_0000};
        seq_m = '{32'd66, 32'd55, 32'd22, 32'd14, 32'd88, 32'd30, 32'd79};
        seq_v = '{32'd96, 32'd13, 32'd90, 32'd84, 32'd88, 32'd10, 32'd69};

        // Reset state
        Rst = 1'b0;
        tick;
        tick;
        check_all_zero("reset");
        Rst = 1'b1;
        tick;

        // Single 7-beat row with exact latency and done timing
        out_ready = 1'b1;
        num_rows  = 16'd1;
        start     = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_mval  = seq_m[i];
            in_vval  = seq_v[i];
            in_last  = (i == 6);
            in_empty = 1'b0;
            chk("seq7_in_ready", {63'd0, in_ready}, 64'd1);
            tick;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("seq7_not_yet_valid", {63'd0, out_valid}, 64'd0);
        tick;
        chk("seq7_valid_at_2", {63'd0, out_valid}, 64'd1);
        chk("seq7_sum", 64'(out_sum), 64'd23702);
        chk("seq7_row", 64'(out_row), 64'd0);
        tick;
        chk("seq7_popped", {63'd0, out_valid}, 64'd0);
        chk("seq7_no_done_yet", {63'd0, done}, 64'd0);
        tick;
        chk("seq7_done", {63'd0, done}, 64'd1);
        chk("seq7_ovf", {63'd0, ovf}, 64'd0);
        out_ready = 1'b0;
        tick;

        // Table-driven single-beat rows
        for (int i = 0; i < 7; i++) begin
            beats.delete();
            beats.push_back('{tbl[i].m, tbl[i].v, 1'b1, tbl[i].empty});
            exp_sum.delete();
            exp_sum.push_back(tbl[i].exp);
            exp_ovf = 1'b0;
            run_job(80, 70, 0, -1);
        end

        // Three rows, middle empty, with a spurious start during RUN
        beats.delete();
        add_row(3, 1'b0, 1'b0);
        add_row(1, 1'b1, 1'b0);
        add_row(2, 1'b0, 1'b0);
        build_expected();
        chk("empty_row_model", 64'(exp_sum[1]), 64'd0);
        run_job(100, 100, 0, 1);

        // Back-pressure: 8 single-beat rows, consumer stalled at first
        beats.delete();
        for (int i = 0; i < 8; i++) add_row(1, 1'b0, 1'b0);
        build_expected();
        run_job(100, 100, 20, -1);
        chk("held_accepts", 64'(held_accepts), 64'(FIFO_DEPTH));

        // Overflow on a single row of two max products
        beats.delete();
        beats.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0});
        beats.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0});
        build_expected();
        run_job(100, 100, 0, -1);
        chk("ovf_sum", 64'(exp_sum[0]), 64'h0000_FFFC_0000_0002);

        // Zero-row job: done one cycle later, start clears ovf
        num_rows = 16'd0;
        start    = 1'b1;
        tick;
        start = 1'b0;
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_busy", {63'd0, busy}, 64'd0);
        chk("zero_ovf_cleared", {63'd0, ovf}, 64'd0);
        chk("zero_in_ready", {63'd0, in_ready}, 64'd0);
        tick;
        chk("zero_done_pulse", {63'd0, done}, 64'd0);
        chk("zero_in_ready_idle", {63'd0, in_ready}, 64'd0);

        // Reset mid-row after 3 beats
        num_rows = 16'd2;
        start    = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mval  = 32'd3 + 32'(i);
            in_vval  = 32'd4;
            in_last  = 1'b0;
            in_empty = 1'b0;
            tick;
        end
        in_valid = 1'b0;
        Rst      = 1'b0;
        tick;
        check_all_zero("midreset");
        Rst = 1'b1;
        tick;
        chk("midreset_no_done", {63'd0, done}, 64'd0);
        beats.delete();
        beats.push_back('{32'd5, 32'd7, 1'b1, 1'b0});
        build_expected();
        run_job(100, 100, 0, -1);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            int nr;
            beats.delete();
            nr = $urandom_range(1, 6);
            for (int r = 0; r < nr; r++)
                add_row($urandom_range(1, 5), ($urandom_range(0, 4) == 0), (j >= 6));
            build_expected();
            run_job($urandom_range(30, 100), $urandom_range(20, 100), 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
